// File: rtl/div_pkg.sv
// Shared constants and types for the iterative restoring divider.
package div_pkg;
  localparam int DIV_W = 32;
  localparam int CNT_W = 5;
  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// subtract the divisor if it fits, emit the quotient bit.
module div_step #(
  parameter int DIV_W = div_pkg::DIV_W
) (
  input  logic [DIV_W-1:0] prem,
  input  logic             dvd_bit,
  input  logic [DIV_W-1:0] dsr,
  output logic [DIV_W-1:0] nrem,
  output logic             qbit
);
  logic [DIV_W:0] shifted;
  logic [DIV_W:0] diff;

  always_comb begin
    shifted = {prem, dvd_bit};
    diff    = shifted - {1'b0, dsr};
    qbit    = (shifted >= {1'b0, dsr});
    nrem    = qbit ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
  end
endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider, one quotient bit per CALC cycle.
// DIVIDER_SIGNED_EN adds the div_signed port and two's-complement fix-up.
module divider
  import div_pkg::*;
#(
  parameter int DIV_W = div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_begin,
`ifdef DIVIDER_SIGNED_EN
  input  logic             div_signed,
`endif
  input  logic [DIV_W-1:0] div_op1,
  input  logic [DIV_W-1:0] div_op2,
  output logic [DIV_W-1:0] div_quo,
  output logic [DIV_W-1:0] div_rem,
  output logic             div_end,
  output logic             div_busy
);
  div_state_e       state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] dvd;   // dividend bits shift out, quotient bits shift in
  logic [DIV_W-1:0] prem;
  logic [DIV_W-1:0] dsr;
  logic [DIV_W-1:0] nrem;
  logic             qbit;

`ifdef DIVIDER_SIGNED_EN
  logic             neg_q, neg_r, div0;
  logic             op1_neg, op2_neg;
  logic [DIV_W-1:0] op1_mag, op2_mag;

  // Negating 0x80..0 wraps back to itself, which is exactly its unsigned magnitude.
  always_comb begin
    op1_neg = div_signed & div_op1[DIV_W-1];
    op2_neg = div_signed & div_op2[DIV_W-1];
    op1_mag = op1_neg ? -div_op1 : div_op1;
    op2_mag = op2_neg ? -div_op2 : div_op2;
  end
`endif

  div_step #(.DIV_W(DIV_W)) u_step (
    .prem    (prem),
    .dvd_bit (dvd[DIV_W-1]),
    .dsr     (dsr),
    .nrem    (nrem),
    .qbit    (qbit)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (div_begin) nxt = CALC;
      CALC:    if (!div_begin) nxt = IDLE;
               else if (cnt == CNT_W'(DIV_W-1)) nxt = DONE;
      DONE:    if (!div_begin) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign div_busy = (state == CALC);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      prem    <= '0;
      dsr     <= '0;
      div_quo <= '0;
      div_rem <= '0;
      div_end <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      // Registered one cycle behind DONE, so it lingers a cycle after div_begin drops.
      div_end <= (state == DONE);
      case (state)
        IDLE: if (div_begin) begin
          cnt  <= '0;
          prem <= '0;
`ifdef DIVIDER_SIGNED_EN
          dvd   <= op1_mag;
          dsr   <= op2_mag;
          neg_q <= op1_neg ^ op2_neg;
          neg_r <= op1_neg;
          div0  <= (div_op2 == '0);
`else
          dvd  <= div_op1;
          dsr  <= div_op2;
`endif
        end
        CALC: begin
          dvd  <= {dvd[DIV_W-2:0], qbit};
          prem <= nrem;
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
`ifdef DIVIDER_SIGNED_EN
          // A zero divisor leaves |op1| in prem; sign restore gives back op1 itself.
          div_quo <= div0 ? DIV_W'(DIV0_QUO) : (neg_q ? -dvd : dvd);
          div_rem <= neg_r ? -prem : prem;
`else
          div_quo <= dvd;
          div_rem <= prem;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: spec vectors, corner sequences, random vs model.
module tb_divider;
  logic        clk = 1'b0;
  logic        resetn;
  logic        div_begin;
  logic        sgn;
  logic [31:0] div_op1, div_op2;
  logic [31:0] div_quo, div_rem;
  logic        div_end, div_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divider dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_begin  (div_begin),
`ifdef DIVIDER_SIGNED_EN
    .div_signed (sgn),
`endif
    .div_op1    (div_op1),
    .div_op2    (div_op2),
    .div_quo    (div_quo),
    .div_rem    (div_rem),
    .div_end    (div_end),
    .div_busy   (div_busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    logic   eff_s;
`ifdef DIVIDER_SIGNED_EN
    eff_s = s;
`else
    eff_s = 1'b0;
`endif
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (eff_s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Start an op, scramble the operands right after the start edge, wait for div_end.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ca, input logic [31:0] cb,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    div_op1 = a; div_op2 = b; sgn = s; div_begin = 1'b1;
    @(posedge clk);
    lat = 0; busy_cnt = 0;
    #1;
    div_op1 = ca; div_op2 = cb; sgn = ~s;
    while (lat < 40) begin
      if (div_busy) busy_cnt++;
      if (div_end) break;
      @(posedge clk); lat++;
      #1;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    div_begin = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat, bc;
    logic [31:0] eq, er, pq, pr;
    logic [31:0] ra, rb;
    logic        rs;

    resetn = 1'b0; div_begin = 1'b1; sgn = 1'b0; div_op1 = 32'd77; div_op2 = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quo", div_quo, 32'd0);
    check("reset_rem", div_rem, 32'd0);
    check("reset_end", 32'(div_end), 32'd0);
    check("reset_busy_dominates_begin", 32'(div_busy), 32'd0);
    @(negedge clk);
    div_begin = 1'b0; resetn = 1'b1;
    @(posedge clk);

    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2});
    vecs.push_back('{32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0});
    vecs.push_back('{32'd5,          32'd9,          1'b0, 32'd0,          32'd5});
    vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000});
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0});
    vecs.push_back('{32'hFFFF_EDCC,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_EDCC});
    vecs.push_back('{32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, $urandom, $urandom, lat, bc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd32);
      check($sformatf("vec%0d_quo", i), div_quo, vecs[i].q);
      check($sformatf("vec%0d_rem", i), div_rem, vecs[i].r);
      if (i == 0) begin
        @(negedge clk);
        div_begin = 1'b0;
        @(posedge clk); #1;
        check("done_end_lingers", 32'(div_end), 32'd1);
        @(posedge clk); #1;
        check("done_end_drops", 32'(div_end), 32'd0);
        check("done_quo_held", div_quo, 32'd14);
        check("done_rem_held", div_rem, 32'd2);
      end else begin
        release_op();
      end
    end

    // Operand change mid-CALC: 50/5 with op1 replaced by 99.
    run_op(32'd50, 32'd5, 1'b0, 32'd99, 32'd5, lat, bc);
    check("opchg_quo", div_quo, 32'd10);
    check("opchg_rem", div_rem, 32'd0);
    pq = div_quo; pr = div_rem;
    release_op();

    // Abort after 10 CALC cycles.
    @(negedge clk);
    div_op1 = 32'd1000; div_op2 = 32'd7; sgn = 1'b0; div_begin = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(div_busy), 32'd1);
    @(negedge clk);
    div_begin = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_busy", 32'(div_busy), 32'd0);
    bc = 0;
    repeat (5) begin
      if (div_end) bc++;
      @(posedge clk); #1;
    end
    check("abort_end_never", 32'(bc), 32'd0);
    check("abort_quo_held", div_quo, pq);
    check("abort_rem_held", div_rem, pr);
    run_op(32'd9, 32'd3, 1'b0, $urandom, $urandom, lat, bc);
    check("restart_latency", 32'(lat), 32'd33);
    check("restart_quo", div_quo, 32'd3);
    check("restart_rem", div_rem, 32'd0);
    release_op();

    // Reset at iteration 20 with div_begin held high.
    @(negedge clk);
    div_op1 = 32'd1000; div_op2 = 32'd10; sgn = 1'b0; div_begin = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midreset_quo", div_quo, 32'd0);
    check("midreset_rem", div_rem, 32'd0);
    check("midreset_end", 32'(div_end), 32'd0);
    check("midreset_busy", 32'(div_busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("postreset_start", 32'(div_busy), 32'd1);
    lat = 0;
    while (lat < 40 && !div_end) begin
      @(posedge clk); lat++; #1;
    end
    check("postreset_latency", 32'(lat), 32'd33);
    check("postreset_quo", div_quo, 32'd100);
    check("postreset_rem", div_rem, 32'd0);
    release_op();

    // Random operations against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 20));
        1: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, eq, er);
      run_op(ra, rb, rs, $urandom, $urandom, lat, bc);
      check($sformatf("rnd%0d_lat a=%08h b=%08h s=%0d", n, ra, rb, rs), 32'(lat), 32'd33);
      check($sformatf("rnd%0d_quo a=%08h b=%08h s=%0d", n, ra, rb, rs), div_quo, eq);
      check($sformatf("rnd%0d_rem a=%08h b=%08h s=%0d", n, ra, rb, rs), div_rem, er);
      release_op();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DIV_W, default 32, operand/result width; all widths below are given for DIV_W=32.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 div_begin  in  1  level request; held high for the whole operation and while the result is read.
REQ-005 div_signed  in  1  1 = two's-complement divide, 0 = unsigned divide; sampled at start (present only with DIV_SIGNED_EN).
REQ-006 div_op1  in  32  dividend; sampled at start.
REQ-007 div_op2  in  32  divisor; sampled at start.
REQ-008 div_quo  out  32  quotient; valid while div_end=1.
REQ-009 div_rem  out  32  remainder; valid while div_end=1.
REQ-010 div_end  out  1  result valid; held high until div_begin falls.
REQ-011 div_busy  out  1  high in CALC.

Function
REQ-012 FSM states IDLE, CALC, DONE.
- IDLE->CALC when div_begin=1.
- CALC->DONE after 32 iterations.
- DONE->IDLE when div_begin=0.
REQ-013 Start (IDLE with div_begin=1): latch |op1|, |op2|, result signs and mode; clear the 5-bit iteration counter and the remainder register.
REQ-014 Each CALC cycle performs one restoring shift-subtract step and produces one quotient bit, MSB first; the 33-bit subtract is compared unsigned.
REQ-015 Latency: div_end rises on the 33rd rising edge after the edge that sampled div_begin high in IDLE; div_busy is high for exactly 32 cycles.
REQ-016 Signed fix-up:
- quotient negated when the operand signs differ;
- remainder carries the dividend's sign;
- |x| is computed as a 32-bit unsigned magnitude, so 0x80000000 maps to 2^31.
REQ-017 Signed overflow 0x80000000 / 0xFFFFFFFF yields div_quo=0x80000000, div_rem=0, with no exception.
REQ-018 Divide by zero yields div_quo=0xFFFFFFFF and div_rem=dividend (original signed value); latency is unchanged.
REQ-019 div_begin falling in CALC aborts to IDLE on the next edge; div_end stays 0 and the outputs keep their previous values.
REQ-020 div_begin falling in DONE returns to IDLE; div_end drops one cycle later; div_quo/div_rem hold their last values.
REQ-021 Operand changes after the start edge have no effect on the current operation.
REQ-022 A new operation requires div_begin low for at least one cycle; there is no back-to-back start from DONE.

Reset
REQ-023 With resetn=0 on a rising edge: state=IDLE, counter=0, div_quo=0, div_rem=0, div_end=0, div_busy=0.
REQ-024 Reset during CALC or DONE discards the operation, with outputs as in REQ-023.
REQ-025 Reset dominates div_begin.

Configuration
REQ-026 Macro DIVIDER_SIGNED_EN:
- defined: the div_signed port exists and REQ-016/REQ-017 apply;
- undefined: the port is absent, all divides are unsigned, no sign fix-up logic is built, and divide-by-zero behaves per REQ-018.

Structure
REQ-027 Shared package div_pkg holds DIV_W, the iteration-counter width (5), the FSM state enum, and the divide-by-zero quotient constant.
REQ-028 One sub-module, div_step: combinational single restoring iteration; inputs are the partial remainder, next dividend bit and divisor; outputs are the new partial remainder and the quotient bit. divider instantiates it once.

Verification
REQ-029 Unsigned 100 / 7 -> div_quo=14, div_rem=2; div_end high at the 33rd edge; div_busy high for 32 cycles.
REQ-030 Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> div_quo=0xFFFFFFFD, div_rem=0xFFFFFFFF; signed 7 / -2 -> div_quo=0xFFFFFFFD, div_rem=1.
REQ-031 Boundary operations:
- 0x1234 / 0 -> div_quo=0xFFFFFFFF, div_rem=0x1234;
- signed 0x80000000 / 0xFFFFFFFF -> div_quo=0x80000000, div_rem=0;
- unsigned 0xFFFFFFFF / 1 -> div_quo=0xFFFFFFFF, div_rem=0.
REQ-032 Abort: drop div_begin after 10 CALC cycles -> IDLE next edge, div_end never asserts; restarting 9 / 3 -> div_quo=3, div_rem=0 after 33 edges.
REQ-033 resetn low for 1 cycle at iteration 20 -> all outputs 0, state IDLE; div_begin still high -> a fresh operation starts on the edge after reset releases.
REQ-034 Operand change mid-CALC: 50 / 5 started, then op1 changed to 99 -> div_quo=10, div_rem=0.
